cloud_vector_sequencer: RTL and testbench
=========================================

Name: cloud_vector_sequencer

Overview:
Sequential stimulus/check controller for the 4-input gate-level cloud (inputs a,b,c,d; outputs o1,o2).
- Drives input vectors onto the cloud and holds each one for a programmable settle window, longer than the cloud's worst-case gate-delay path.
- Samples o1/o2 and compares them against an internal golden model; counts mismatches and captures the first failing vector.
- Sits between the testbench/top-level and the cloud instance; the cloud itself stays purely combinational.

Parameters:
SETTLE_CYCLES, 4, clocks each vector is held before sampling; legal range 1..255.
CNT_W, 8, width of the internal settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  run request; sampled only in IDLE.
mode_sweep  input  1  1 = exhaustive sweep of vectors 0..15; 0 = single vector vec_in.
vec_in  input  4  single-mode vector; bit3=a, bit2=b, bit1=c, bit0=d; captured when start is accepted.
abort  input  1  stop the run immediately.
cloud_a, cloud_b, cloud_c, cloud_d  output  1 each  registered drive to the cloud inputs.
cloud_o1, cloud_o2  input  1 each  cloud outputs.
busy  output  1  high from the cycle after start is accepted until the done cycle (inclusive of the last SAMPLE).
done  output  1  one-cycle pulse at run completion.
pass  output  1  valid when done is high; 1 iff err_count==0.
err_count  output  5  mismatch count for the current run; saturates at 31.
fail_valid  output  1  a mismatch has occurred in the current run.
fail_vec  output  4  vector of the first mismatch; 0 while fail_valid is 0.

Behaviour:
- Reset (async, rst_n low): state IDLE; every output 0, including cloud_a..d.
- Golden model:
  - exp_o2 = a|b|d
  - exp_o1 = (a|b|d) & ~((a|b)&c)
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → DRIVE.
  - On acceptance: clear err_count, fail_valid and fail_vec.
  - Vector index = 0 in sweep mode, else vec_in.
- DRIVE (1 cycle): register the vector onto cloud_a..d; load settle counter = SETTLE_CYCLES → SETTLE.
- SETTLE: decrement the counter each cycle; at 0 → SAMPLE. Drives stay stable throughout.
- SAMPLE (1 cycle): compare cloud_o1/o2 with the golden model for the driven vector.
  - On mismatch: err_count++ (saturating).
  - If fail_valid was 0: set fail_valid and load fail_vec.
  - Next state:
    - single mode → DONE;
    - sweep mode and vector==15 → DONE;
    - otherwise increment the vector and go to DRIVE.
- DONE (1 cycle): done=1, pass valid → IDLE.
  - err_count, fail_valid and fail_vec hold until the next start is accepted.
  - cloud_a..d hold their last drive.
- Timing:
  - Cycles per vector = SETTLE_CYCLES+2.
  - done is asserted 1 + N*(SETTLE_CYCLES+2) cycles after the start-accept edge, where N=16 (sweep) or 1 (single).
- start while busy: ignored. start in the DONE cycle: ignored.
- abort:
  - In any non-IDLE state → IDLE next cycle; no done pulse.
  - Counters and fail capture hold their values.
  - cloud_a..d return to 0.
- Simultaneous events:
  - abort and start in IDLE: abort wins; the run does not start.
  - Mismatch on the last vector: counted before done.
- Reset mid-run: immediate return to reset values; no done pulse.

Optional Feature:
Macro SEQ_FAIL_STOP_EN.
- Defined: in sweep mode the first mismatch ends the run. SAMPLE goes → DONE with pass=0, err_count=1, fail_vec = the failing vector.
- Undefined: the sweep always covers all 16 vectors and err_count is the total mismatch count.

Test Plan:
- Correct cloud, sweep, SETTLE_CYCLES=4 → done exactly 97 cycles after start-accept; pass=1; err_count=0; fail_valid=0.
- Cloud o1 forced stuck-at-0, sweep:
  - without the macro → err_count=8, fail_vec=4'h1, pass=0;
  - with SEQ_FAIL_STOP_EN → err_count=1, fail_vec=4'h1, done after 13 cycles.
- Cloud o2 forced stuck-at-1, sweep → err_count=2 (vectors 0 and 2), fail_vec=4'h0.
- Single mode:
  - vec_in=4'hA → cloud_a..d=1,0,1,0 during SETTLE; expected o1=0, o2=1; pass=1; done 7 cycles after accept.
  - vec_in=4'h1 → expected o1=1, o2=1; pass=1.
- Abort asserted during SETTLE of vector 5 → IDLE next cycle; no done; cloud_a..d=0; a new start then runs a full sweep to pass=1.
- rst_n pulsed low mid-sweep (asynchronously, between edges) → all outputs 0 immediately; start pulses while busy are ignored (the run length is unchanged).

Source files
------------

// File: rtl/cloud_vector_sequencer.sv
`timescale 1ns/1ps
// cloud_vector_sequencer
//
// Stimulus/check controller for the 4-input combinational cloud
// (inputs a,b,c,d; outputs o1,o2). Each vector is registered onto the cloud
// inputs and held for SETTLE_CYCLES clocks. The cloud outputs are then sampled
// and compared against a built-in golden model:
//   exp_o2 = a | b | d
//   exp_o1 = (a | b | d) & ~((a | b) & c)
// The block counts mismatches (saturating at 31) and captures the first
// failing vector.
//
// Optional feature, selected by the macro SEQ_FAIL_STOP_EN:
//   defined   - in sweep mode the first mismatch ends the run (goes to DONE).
//   undefined - a sweep always covers all 16 vectors.
//
// Parameters:
//   SETTLE_CYCLES - clocks each vector is held before sampling (1..255).
//   CNT_W         - settle counter width; must be able to hold SETTLE_CYCLES.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset.
//   start               - run request, sampled only in IDLE.
//   mode_sweep          - 1: sweep vectors 0..15, 0: single vector vec_in.
//   vec_in[3:0]         - single-mode vector {a,b,c,d}, captured on accept.
//   abort               - abandon the run; back to IDLE with no done pulse.
//   cloud_a..cloud_d    - registered drive to the cloud inputs.
//   cloud_o1, cloud_o2  - cloud outputs.
//   busy                - high in DRIVE, SETTLE and SAMPLE.
//   done                - one-cycle pulse at run completion.
//   pass                - meaningful while done is high; 1 iff no mismatch.
//   err_count[4:0]      - mismatches in the current run, saturating at 31.
//   fail_valid          - a mismatch has been seen in the current run.
//   fail_vec[3:0]       - first failing vector; 0 while fail_valid is 0.
//   dbg_state[2:0]      - current FSM state encoding (IDLE = 0).
//
// Handshake: start is a level request that the block consumes in any IDLE cycle
// where abort is low; there is no ready. While a run is active (busy) or during
// the DONE cycle, start is ignored.

module cloud_vector_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode_sweep,
    input  logic [3:0] vec_in,
    input  logic       abort,
    output logic       cloud_a,
    output logic       cloud_b,
    output logic       cloud_c,
    output logic       cloud_d,
    input  logic       cloud_o1,
    input  logic       cloud_o2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] fail_vec,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // SETTLE counts from SETTLE_CYCLES-1 down to 0 inclusive, so the vector is
    // held for exactly SETTLE_CYCLES clocks and a vector takes SETTLE_CYCLES+2.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] settle_cnt;
    logic [3:0]       vec_idx;     // next vector to drive
    logic             sweep_r;     // run mode captured on accept
    logic [3:0]       cloud_vec;   // vector currently on the cloud inputs

    logic             exp_o1;
    logic             exp_o2;
    logic             mismatch;
    logic             last_vec;
    logic             stop_early;
    logic             accept;

    // ------------------------------------------------------------------
    // Golden model, evaluated on the vector actually driven on the cloud.
    // ------------------------------------------------------------------
    always_comb begin
        exp_o2   = cloud_vec[3] | cloud_vec[2] | cloud_vec[0];
        exp_o1   = exp_o2 & ~((cloud_vec[3] | cloud_vec[2]) & cloud_vec[1]);
        mismatch = (cloud_o1 != exp_o1) || (cloud_o2 != exp_o2);
    end

    assign last_vec = !sweep_r || (vec_idx == 4'hF);
    assign accept   = (state == ST_IDLE) && start && !abort;

`ifdef SEQ_FAIL_STOP_EN
    assign stop_early = sweep_r && mismatch;
`else
    assign stop_early = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_n = abort ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (settle_cnt == '0) begin
                    state_n = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (last_vec || stop_early) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: vector index, cloud drive, settle counter, error capture.
    // Error state holds across abort and DONE; only an accepted start clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vec_idx    <= 4'h0;
            sweep_r    <= 1'b0;
            cloud_vec  <= 4'h0;
            err_count  <= 5'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err_count  <= 5'd0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 4'h0;
                        sweep_r    <= mode_sweep;
                        vec_idx    <= mode_sweep ? 4'h0 : vec_in;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        cloud_vec <= 4'h0;
                    end else begin
                        cloud_vec  <= vec_idx;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        cloud_vec <= 4'h0;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        cloud_vec <= 4'h0;
                    end else begin
                        if (mismatch) begin
                            if (err_count != 5'd31) begin
                                err_count <= err_count + 5'd1;
                            end
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_vec   <= cloud_vec;
                            end
                        end
                        if (!(last_vec || stop_early)) begin
                            vec_idx <= vec_idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        cloud_vec <= 4'h0;
                    end
                end
                default: begin
                    cloud_vec <= 4'h0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cloud_a   = cloud_vec[3];
    assign cloud_b   = cloud_vec[2];
    assign cloud_c   = cloud_vec[1];
    assign cloud_d   = cloud_vec[0];
    assign busy      = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done      = (state == ST_DONE);
    assign pass      = (state == ST_DONE) && (err_count == 5'd0);
    assign dbg_state = state;

endmodule

// File: tb/tb_cloud_vector_sequencer.sv
`timescale 1ns/1ps
// Testbench for cloud_vector_sequencer: a behavioural cloud with fault
// injection, a vector table of spec scenarios, hand-written corner sequences
// (abort, reset, start collisions) and randomized fault masks checked against
// a reference model.

module tb_cloud_vector_sequencer;

    localparam int S = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode_sweep;
    logic [3:0] vec_in;
    logic       abort;
    logic       cloud_a, cloud_b, cloud_c, cloud_d;
    logic       cloud_o1, cloud_o2;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_vec;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    cloud_vector_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode_sweep (mode_sweep),
        .vec_in     (vec_in),
        .abort      (abort),
        .cloud_a    (cloud_a),
        .cloud_b    (cloud_b),
        .cloud_c    (cloud_c),
        .cloud_d    (cloud_d),
        .cloud_o1   (cloud_o1),
        .cloud_o2   (cloud_o2),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec),
        .dbg_state  (dbg_state)
    );

    // ------------------------------------------------------------------
    // Behavioural cloud with fault injection
    //   0: correct  1: o1 stuck-at-0  2: o2 stuck-at-1  3: per-vector flips
    // ------------------------------------------------------------------
    int          fault_kind;
    logic [15:0] flip1, flip2;
    logic [3:0]  cv;
    logic        t1, t2;

    always_comb begin
        cv = {cloud_a, cloud_b, cloud_c, cloud_d};
        t2 = cloud_a | cloud_b | cloud_d;
        t1 = t2 & ~((cloud_a | cloud_b) & cloud_c);
        cloud_o1 = t1;
        cloud_o2 = t2;
        case (fault_kind)
            1: cloud_o1 = 1'b0;
            2: cloud_o2 = 1'b1;
            3: begin
                cloud_o1 = t1 ^ flip1[cv];
                cloud_o2 = t2 ^ flip2[cv];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard counters and checker
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: run one complete test and report the results seen on done
    // ------------------------------------------------------------------
    task automatic run_vec(input logic sweep, input logic [3:0] vec, input bit noise,
                           output int cyc, output logic [4:0] err, output logic fv,
                           output logic [3:0] fvec, output logic ps);
        bit got;
        @(negedge clk);
        start = 1'b1; mode_sweep = sweep; vec_in = vec;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; got = 0;
        err = '0; fv = 1'b0; fvec = '0; ps = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got  = 1;
                err  = err_count;
                fv   = fail_valid;
                fvec = fail_vec;
                ps   = pass;
                // a start raised during the DONE cycle must be ignored
                start = noise;
            end else if (noise) begin
                start = 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            cyc = -1;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: mismatch iff the cloud's output differs from the
    // golden function, expressed here through the per-vector flip masks.
    // ------------------------------------------------------------------
    task automatic ref_model(input logic sweep, input logic [3:0] vec,
                             input logic [15:0] f1, input logic [15:0] f2,
                             output int e_cyc, output int e_err, output logic e_fv,
                             output logic [3:0] e_fvec, output logic e_pass);
        int q[$];
        int n;
        q = {};
        if (sweep) begin
            for (int v = 0; v < 16; v++) q.push_back(v);
        end else begin
            q.push_back(int'(vec));
        end
        n = 0; e_err = 0; e_fv = 1'b0; e_fvec = 4'h0;
        foreach (q[i]) begin
            n++;
            if (f1[q[i]] || f2[q[i]]) begin
                e_err++;
                if (!e_fv) begin
                    e_fv   = 1'b1;
                    e_fvec = 4'(q[i]);
                end
`ifdef SEQ_FAIL_STOP_EN
                if (sweep) break;
`endif
            end
        end
        if (e_err > 31) e_err = 31;
        e_cyc  = 1 + n * (S + 2);
        e_pass = (e_err == 0);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       sweep;
        logic [3:0] vec;
        int         fault;
        int         exp_err;
        logic       exp_fv;
        logic [3:0] exp_fvec;
        logic       exp_pass;
        int         exp_cyc;
    } vec_t;

    function automatic vec_t mk(input logic sw, input logic [3:0] v, input int f, input int e,
                                input logic fv, input logic [3:0] fvc, input logic p, input int c);
        vec_t r;
        r.sweep = sw; r.vec = v; r.fault = f; r.exp_err = e;
        r.exp_fv = fv; r.exp_fvec = fvc; r.exp_pass = p; r.exp_cyc = c;
        return r;
    endfunction

    vec_t tbl[9];

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int          cyc, e_cyc, e_err, n_done;
    logic [4:0]  err;
    logic        fv, ps, e_fv, e_pass;
    logic [3:0]  fvec, e_fvec;
    logic        sw;
    logic [3:0]  v;

    initial begin
        tbl[0] = mk(1'b1, 4'h0, 0, 0, 1'b0, 4'h0, 1'b1, 97);
`ifdef SEQ_FAIL_STOP_EN
        tbl[1] = mk(1'b1, 4'h0, 1, 1, 1'b1, 4'h1, 1'b0, 13);
        tbl[2] = mk(1'b1, 4'h0, 2, 1, 1'b1, 4'h0, 1'b0, 7);
`else
        tbl[1] = mk(1'b1, 4'h0, 1, 8, 1'b1, 4'h1, 1'b0, 97);
        tbl[2] = mk(1'b1, 4'h0, 2, 2, 1'b1, 4'h0, 1'b0, 97);
`endif
        tbl[3] = mk(1'b0, 4'hA, 0, 0, 1'b0, 4'h0, 1'b1, 7);
        tbl[4] = mk(1'b0, 4'h1, 0, 0, 1'b0, 4'h0, 1'b1, 7);
        tbl[5] = mk(1'b0, 4'hA, 1, 0, 1'b0, 4'h0, 1'b1, 7);
        tbl[6] = mk(1'b0, 4'h1, 1, 1, 1'b1, 4'h1, 1'b0, 7);
        tbl[7] = mk(1'b0, 4'h0, 2, 1, 1'b1, 4'h0, 1'b0, 7);
        tbl[8] = mk(1'b0, 4'hF, 2, 0, 1'b0, 4'h0, 1'b1, 7);

        rst_n = 1'b0; start = 1'b0; mode_sweep = 1'b0; vec_in = 4'h0; abort = 1'b0;
        fault_kind = 0; flip1 = '0; flip2 = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {busy, done, pass, err_count, fail_valid, fail_vec,
                              cloud_a, cloud_b, cloud_c, cloud_d}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table
        for (int i = 0; i < 9; i++) begin
            fault_kind = tbl[i].fault;
            run_vec(tbl[i].sweep, tbl[i].vec, 1'b0, cyc, err, fv, fvec, ps);
            check($sformatf("t%0d_cycles", i), cyc, tbl[i].exp_cyc);
            check($sformatf("t%0d_err", i), {27'd0, err}, tbl[i].exp_err);
            check($sformatf("t%0d_fail_valid", i), {31'd0, fv}, {31'd0, tbl[i].exp_fv});
            check($sformatf("t%0d_fail_vec", i), {28'd0, fvec}, {28'd0, tbl[i].exp_fvec});
            check($sformatf("t%0d_pass", i), {31'd0, ps}, {31'd0, tbl[i].exp_pass});
        end

        // single vector A: drive visible and stable during SETTLE
        fault_kind = 0;
        @(negedge clk);
        start = 1'b1; mode_sweep = 1'b0; vec_in = 4'hA;
        @(posedge clk);
        #1 start = 1'b0;
        vec_in = 4'h3;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 2 || c == 5) begin
                check($sformatf("single_a_drive_c%0d", c),
                      {28'd0, cloud_a, cloud_b, cloud_c, cloud_d}, 32'hA);
                check($sformatf("single_a_busy_c%0d", c), {31'd0, busy}, 32'd1);
            end
            if (c == 7) check("single_a_done", {30'd0, done, pass}, 32'd3);
        end

        // abort during SETTLE of vector 5
`ifdef SEQ_FAIL_STOP_EN
        fault_kind = 0;
`else
        fault_kind = 3; flip1 = 16'h0008; flip2 = 16'h0000;
`endif
        @(negedge clk);
        start = 1'b1; mode_sweep = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 33; c++) @(negedge clk);
        check("abort_pre_drive", {28'd0, cloud_a, cloud_b, cloud_c, cloud_d}, 32'h5);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle", {29'd0, dbg_state}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_drive_zero", {28'd0, cloud_a, cloud_b, cloud_c, cloud_d}, 32'd0);
`ifdef SEQ_FAIL_STOP_EN
        check("abort_hold_err", {27'd0, err_count, fail_valid, fail_vec}, 32'd0);
`else
        check("abort_hold_err", {27'd0, err_count, fail_valid, fail_vec}, {27'd0, 5'd1, 1'b1, 4'h3});
`endif
        n_done = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        fault_kind = 0;
        run_vec(1'b1, 4'h0, 1'b0, cyc, err, fv, fvec, ps);
        check("post_abort_cycles", cyc, 97);
        check("post_abort_pass", {31'd0, ps}, 32'd1);

        // abort together with start in IDLE: no run, error state untouched
        fault_kind = 2;
        run_vec(1'b1, 4'h0, 1'b0, cyc, err, fv, fvec, ps);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_idle", {28'd0, busy, dbg_state}, 32'd0);
`ifdef SEQ_FAIL_STOP_EN
        check("abort_start_err_held", {27'd0, err_count}, 32'd1);
`else
        check("abort_start_err_held", {27'd0, err_count}, 32'd2);
`endif

        // asynchronous reset mid-sweep with start noise
        @(negedge clk);
        start = 1'b1; mode_sweep = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {busy, done, pass, err_count, fail_valid, fail_vec,
                                 cloud_a, cloud_b, cloud_c, cloud_d}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, 32'd0);
        #1 rst_n = 1'b1;
        fault_kind = 0;
        run_vec(1'b1, 4'h0, 1'b1, cyc, err, fv, fvec, ps);
        check("noisy_sweep_cycles", cyc, 97);
        check("noisy_sweep_pass", {31'd0, ps}, 32'd1);

        // randomized fault masks against the reference model
        fault_kind = 3;
        for (int r = 0; r < 24; r++) begin
            sw = 1'($urandom_range(0, 1));
            v  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                flip1 = '0; flip2 = '0;
            end else begin
                flip1 = 16'($urandom) & 16'($urandom);
                flip2 = 16'($urandom) & 16'($urandom);
            end
            ref_model(sw, v, flip1, flip2, e_cyc, e_err, e_fv, e_fvec, e_pass);
            run_vec(sw, v, r[0], cyc, err, fv, fvec, ps);
            check($sformatf("rnd%0d_cycles", r), cyc, e_cyc);
            check($sformatf("rnd%0d_err", r), {27'd0, err}, e_err);
            check($sformatf("rnd%0d_fail", r), {27'd0, fv, fvec}, {27'd0, e_fv, e_fvec});
            check($sformatf("rnd%0d_pass", r), {31'd0, ps}, {31'd0, e_pass});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
